// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared types and helpers for the memory-stage load/store engine
package mem_access_unit_pkg;

   typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} mau_state_t;

   function automatic logic [3:0] size_bytes(msize_t s);
      return 4'd1 << s;
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_access_unit_lane_align: store lane shift/strobe and load shift/mask/extend
module mem_access_unit_lane_align
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_W = 64,
   localparam int NB = DATA_W / 8,
   localparam int OFF_W = $clog2(NB)
) (
   input  msize_t              size_i,
   input  logic                zext_i,
   input  logic [OFF_W-1:0]    lane_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W-1:0]   rdata_i,
   output logic [DATA_W-1:0]   st_data_o,
   output logic [NB-1:0]       st_strobe_o,
   output logic [DATA_W-1:0]   ld_data_o
);

   logic [3:0]        bytes;
   logic [OFF_W+2:0]  sh;
   logic [NB-1:0]     lo;
   logic [DATA_W-1:0] raw;
   logic [DATA_W-1:0] mask;

   // Full-width masks rely on the shift overflowing to 0 so that 0 - 1 yields all ones.
   always_comb begin
      bytes = size_bytes(size_i);
      sh = {lane_i, 3'b000};
      lo = (NB'(1) << bytes) - NB'(1);
      st_strobe_o = lo << lane_i;
      st_data_o = wdata_i << sh;
      raw = rdata_i >> sh;
      mask = (DATA_W'(1) << {bytes, 3'b000}) - DATA_W'(1);
      ld_data_o = (raw & mask) | ((!zext_i && |(raw & (mask ^ (mask >> 1)))) ? ~mask : '0);
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one data-bus transaction per memory instruction, with alignment, misalign and flush handling
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64,
   localparam int NB = DATA_W / 8,
   localparam int OFF_W = $clog2(NB)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   input  logic              in_load_i,
   input  logic              in_store_i,
   input  msize_t            in_size_i,
   input  logic              in_zext_i,
   input  logic [ADDR_W-1:0] in_addr_i,
   input  logic [DATA_W-1:0] in_wdata_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_rdata_o,
   output logic              out_misalign_o,
   output logic              req_valid_o,
   output logic [ADDR_W-1:0] req_addr_o,
   output msize_t            req_size_o,
   output logic [NB-1:0]     req_strobe_o,
   output logic [DATA_W-1:0] req_data_o,
   input  logic              resp_addr_ok_i,
   input  logic              resp_data_ok_i,
   input  logic [DATA_W-1:0] resp_data_i
);

   mau_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   msize_t            size_q;
   logic              zext_q, st_q, mis_q, drop_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic              start, illegal, capture;
   logic [3:0]        bytes;
   logic [OFF_W-1:0]  in_lane;
   logic [DATA_W-1:0] st_data, ld_data;
   logic [NB-1:0]     st_strobe;

   always_comb begin
      bytes = size_bytes(in_size_i);
      in_lane = in_addr_i[OFF_W-1:0];
      start = in_valid_i && (in_load_i || in_store_i) && !flush_i;
      illegal = (32'(bytes) > NB) || ((in_lane & OFF_W'(bytes - 4'd1)) != '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = start ? (illegal ? S_DONE : S_ADDR) : S_IDLE;
         S_ADDR:  state_d = resp_addr_ok_i ? (resp_data_ok_i ? S_DONE : S_DATA) : S_ADDR;
         S_DATA:  state_d = resp_data_ok_i ? S_DONE : S_DATA;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall_o = (state_q == S_IDLE && start) || state_q == S_ADDR || state_q == S_DATA;
      out_valid_o = state_q == S_DONE && !drop_q && !flush_i;
      out_misalign_o = out_valid_o && mis_q;
      req_valid_o = state_q == S_ADDR;
      capture = (state_q == S_ADDR && resp_addr_ok_i && resp_data_ok_i) || (state_q == S_DATA && resp_data_ok_i);
   end

   // A flush mid-transaction lets the bus finish and only discards the result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         size_q  <= MSIZE1;
         zext_q  <= 1'b0;
         st_q    <= 1'b0;
         mis_q   <= 1'b0;
         drop_q  <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            addr_q  <= in_addr_i;
            size_q  <= in_size_i;
            zext_q  <= in_zext_i;
            st_q    <= in_store_i;
            mis_q   <= illegal;
            wdata_q <= in_wdata_i;
         end
         if (capture) rdata_q <= st_q ? '0 : ld_data;
         drop_q <= state_q == S_DONE ? 1'b0 : drop_q || (flush_i && (state_q == S_ADDR || state_q == S_DATA));
      end
   end

   mem_access_unit_lane_align #(.DATA_W(DATA_W)) u_lane_align (
      .size_i      (size_q),
      .zext_i      (zext_q),
      .lane_i      (addr_q[OFF_W-1:0]),
      .wdata_i     (wdata_q),
      .rdata_i     (resp_data_i),
      .st_data_o   (st_data),
      .st_strobe_o (st_strobe),
      .ld_data_o   (ld_data)
   );

   assign req_addr_o = addr_q;
   assign req_size_o = size_q;
   assign req_strobe_o = st_q ? st_strobe : '0;
   assign req_data_o = st_q ? st_data : '0;
   assign out_rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors, corner sequences and random ops against a byte-level model
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int NB = 8;

   typedef struct {
      logic        ld;
      logic [1:0]  sz;
      logic        zx;
      logic [63:0] addr, wd, rd;
      int          aw, dw;
      logic        mis;
      logic [63:0] rdata;
      logic [7:0]  strb;
      logic [63:0] data;
   } vec_t;

   logic clk = 1'b0, rst_ni = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid = 0, in_load = 0, in_store = 0, in_zext = 0, flush = 0;
   msize_t      in_size = MSIZE1;
   logic [63:0] in_addr = '0, in_wdata = '0, resp_data = '0;
   logic        addr_ok = 0, data_ok = 0;
   logic        stall, out_valid, out_misalign, req_valid;
   logic [63:0] out_rdata, req_addr, req_data;
   msize_t      req_size;
   logic [7:0]  req_strobe;

   logic        v32 = 0;
   logic        s32, ov32, mis32, rv32;
   logic [31:0] rd32, rq32;
   logic [63:0] ra32;
   msize_t      rs32;
   logic [3:0]  rst32;

   int cmp = 0, err = 0;

   mem_access_unit #(.DATA_W(64), .ADDR_W(64)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_load_i(in_load), .in_store_i(in_store),
      .in_size_i(in_size), .in_zext_i(in_zext), .in_addr_i(in_addr), .in_wdata_i(in_wdata), .flush_i(flush),
      .stall_o(stall), .out_valid_o(out_valid), .out_rdata_o(out_rdata), .out_misalign_o(out_misalign),
      .req_valid_o(req_valid), .req_addr_o(req_addr), .req_size_o(req_size), .req_strobe_o(req_strobe),
      .req_data_o(req_data), .resp_addr_ok_i(addr_ok), .resp_data_ok_i(data_ok), .resp_data_i(resp_data)
   );

   mem_access_unit #(.DATA_W(32), .ADDR_W(64)) dut32 (
      .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(v32), .in_load_i(1'b1), .in_store_i(1'b0),
      .in_size_i(MSIZE8), .in_zext_i(1'b0), .in_addr_i(64'h1000), .in_wdata_i(32'h0), .flush_i(1'b0),
      .stall_o(s32), .out_valid_o(ov32), .out_rdata_o(rd32), .out_misalign_o(mis32),
      .req_valid_o(rv32), .req_addr_o(ra32), .req_size_o(rs32), .req_strobe_o(rst32),
      .req_data_o(rq32), .resp_addr_ok_i(1'b0), .resp_data_ok_i(1'b0), .resp_data_i(32'h0)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      cmp++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Byte-level reference: lanes, strobes and extension from the size/offset rules.
   function automatic vec_t model(input vec_t v, input logic [63:0] prev);
      int n, lane;
      logic [63:0] val;
      n = 1 << v.sz;
      lane = int'(v.addr % 64'(NB));
      v.mis = (n > NB) || (lane % n != 0);
      v.strb = '0;
      v.data = '0;
      v.rdata = prev;
      if (!v.mis && !v.ld) begin
         v.rdata = '0;
         for (int i = 0; i < NB; i++) begin
            if (i >= lane && i < lane + n) v.strb[i] = 1'b1;
            if (i >= lane) v.data[8*i +: 8] = v.wd[8*(i-lane) +: 8];
         end
      end
      if (!v.mis && v.ld) begin
         val = '0;
         for (int i = 0; i < n; i++) val[8*i +: 8] = v.rd[8*(lane+i) +: 8];
         if (!v.zx && n < NB && val[8*n-1]) for (int i = 8*n; i < 64; i++) val[i] = 1'b1;
         v.rdata = val;
      end
      return v;
   endfunction

   // Drives one op, answers the bus after aw request cycles and dw data cycles, and watches protocol rules.
   task automatic op(input vec_t v, output int lat, output logic mis, output logic [63:0] rdat,
                     output logic [63:0] rqd, output logic [7:0] strb, output logic ok);
      int nreq, ndat;
      logic acc, seen;
      logic [63:0] ra0, rd0;
      logic [7:0] rs0;
      msize_t rz0;
      nreq = 0; ndat = 0; acc = 0; seen = 0; ok = 1; lat = -1; mis = 0; rdat = '0; rqd = '0; strb = '0;
      ra0 = '0; rd0 = '0; rs0 = '0; rz0 = MSIZE1;
      in_valid = 1; in_load = v.ld; in_store = !v.ld; in_size = msize_t'(v.sz); in_zext = v.zx;
      in_addr = v.addr; in_wdata = v.wd; resp_data = v.rd;
      #1 chk("stall_at_start", 64'(stall), 64'd1);
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         @(negedge clk);
         in_valid = 0; addr_ok = 0; data_ok = 0;
         #1;
         if (out_valid) begin
            lat = c; mis = out_misalign; rdat = out_rdata;
            if (stall) ok = 0;
         end else begin
            if (!stall) ok = 0;
            if (req_valid) begin
               if (acc) ok = 0;
               if (!seen) begin
                  seen = 1; ra0 = req_addr; rs0 = req_strobe; rd0 = req_data; rz0 = req_size;
                  rqd = req_data; strb = req_strobe;
               end else if ({req_addr, req_strobe, req_data, req_size} !== {ra0, rs0, rd0, rz0}) ok = 0;
               if (req_addr !== v.addr || req_size !== msize_t'(v.sz)) ok = 0;
               if (nreq == v.aw) begin
                  addr_ok = 1; acc = 1; data_ok = (v.dw == 0);
               end
               nreq++;
            end else if (acc) begin
               ndat++;
               data_ok = (ndat == v.dw);
            end else ok = 0;
         end
      end
      @(negedge clk);
      addr_ok = 0; data_ok = 0;
      #1 chk("pulse_end", {62'd0, out_valid, stall}, 64'd0);
   endtask

   task automatic run(input vec_t v, input string nm);
      int lat;
      logic mis, ok;
      logic [63:0] rdat, rqd;
      logic [7:0] strb;
      op(v, lat, mis, rdat, rqd, strb, ok);
      chk({nm, ".latency"}, 64'(lat), 64'(v.mis ? 1 : 2 + v.aw + v.dw));
      chk({nm, ".misalign"}, 64'(mis), 64'(v.mis));
      chk({nm, ".rdata"}, rdat, v.rdata);
      chk({nm, ".strobe"}, 64'(strb), 64'(v.strb));
      chk({nm, ".req_data"}, rqd, v.data);
      chk({nm, ".protocol"}, 64'(ok), 64'd1);
   endtask

   vec_t tab[10];
   vec_t r;
   logic [63:0] prev;
   logic seen;

   initial begin
      tab[0] = '{1'b1, 2'd0, 1'b0, 64'h1005, 64'h0, 64'h0000_8000_0000_0000, 0, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0};
      tab[1] = '{1'b1, 2'd0, 1'b1, 64'h1005, 64'h0, 64'h0000_8000_0000_0000, 0, 0, 1'b0, 64'h80, 8'h00, 64'h0};
      tab[2] = '{1'b0, 2'd1, 1'b0, 64'h102, 64'hBEEF, 64'h0, 3, 0, 1'b0, 64'h0, 8'h0C, 64'h0000_0000_BEEF_0000};
      tab[3] = '{1'b1, 2'd2, 1'b0, 64'h2004, 64'h0, 64'h8765_4321_0000_0000, 1, 3, 1'b0, 64'hFFFF_FFFF_8765_4321, 8'h00, 64'h0};
      tab[4] = '{1'b1, 2'd2, 1'b0, 64'h1002, 64'h0, 64'h0, 0, 0, 1'b1, 64'hFFFF_FFFF_8765_4321, 8'h00, 64'h0};
      tab[5] = '{1'b1, 2'd3, 1'b0, 64'h3000, 64'h0, 64'h1122_3344_5566_7788, 0, 1, 1'b0, 64'h1122_3344_5566_7788, 8'h00, 64'h0};
      tab[6] = '{1'b0, 2'd3, 1'b0, 64'h8, 64'hDEAD_BEEF_0123_4567, 64'h0, 2, 2, 1'b0, 64'h0, 8'hFF, 64'hDEAD_BEEF_0123_4567};
      tab[7] = '{1'b0, 2'd0, 1'b0, 64'h7, 64'hAB, 64'h0, 0, 0, 1'b0, 64'h0, 8'h80, 64'hAB00_0000_0000_0000};
      tab[8] = '{1'b1, 2'd1, 1'b0, 64'h6, 64'h0, 64'h8001_0000_0000_0000, 0, 2, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0};
      tab[9] = '{1'b0, 2'd3, 1'b0, 64'h4, 64'h55, 64'h0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0};

      #1 chk("reset.outputs", {|out_rdata, |req_addr, |req_data, |req_strobe, req_size, stall, out_valid, out_misalign, req_valid}, 64'd0);
      repeat (2) @(negedge clk);
      rst_ni = 1;
      @(negedge clk);
      #1;
      foreach (tab[i]) run(tab[i], $sformatf("vec%0d", i));

      in_valid = 1; in_load = 0; in_store = 0;
      #1 chk("nonmem.stall", 64'(stall), 64'd0);
      @(negedge clk);
      in_valid = 0;
      #1 chk("nonmem.idle", {61'd0, out_valid, req_valid, stall}, 64'd0);

      v32 = 1;
      #1 chk("w32.stall", 64'(s32), 64'd1);
      @(negedge clk);
      v32 = 0;
      #1 chk("w32.misalign", {61'd0, ov32, mis32, rv32}, 64'b110);

      in_valid = 1; in_load = 1; in_store = 0; in_size = MSIZE1; in_addr = 64'h10; resp_data = 64'hFF;
      @(negedge clk);
      in_valid = 0;
      #1 chk("flush.req", 64'(req_valid), 64'd1);
      addr_ok = 1;
      @(negedge clk);
      addr_ok = 0; flush = 1;
      #1 chk("flush.stall", 64'(stall), 64'd1);
      @(negedge clk);
      flush = 0; data_ok = 1;
      @(negedge clk);
      data_ok = 0; seen = 0;
      repeat (3) begin
         #1 seen |= out_valid;
         @(negedge clk);
      end
      #1 chk("flush.no_valid", 64'(seen), 64'd0);
      chk("flush.idle", {62'd0, stall, req_valid}, 64'd0);
      run(tab[0], "flush.next");

      in_valid = 1; in_load = 1; in_store = 0; in_size = MSIZE8; in_addr = 64'h20;
      @(negedge clk);
      in_valid = 0;
      #1 addr_ok = 1;
      @(negedge clk);
      addr_ok = 0;
      #1 rst_ni = 0;
      #1 chk("rst.outputs", {|out_rdata, |req_addr, |req_data, |req_strobe, req_size, stall, out_valid, out_misalign, req_valid}, 64'd0);
      @(negedge clk);
      rst_ni = 1; data_ok = 1;
      @(negedge clk);
      data_ok = 0; seen = 0;
      repeat (3) begin
         #1 seen |= out_valid;
         @(negedge clk);
      end
      #1 chk("rst.no_valid", 64'(seen), 64'd0);

      prev = '0;
      for (int i = 0; i < 150; i++) begin
         r.ld = 1'($urandom % 2); r.sz = 2'($urandom % 4); r.zx = 1'($urandom % 2);
         r.addr = {$urandom, $urandom};
         if ($urandom % 4 != 0) r.addr = r.addr & ~64'((1 << r.sz) - 1);
         r.wd = {$urandom, $urandom}; r.rd = {$urandom, $urandom};
         r.aw = int'($urandom % 4); r.dw = int'($urandom % 4);
         r = model(r, prev);
         prev = r.rdata;
         run(r, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
